puf_host_link: RTL and testbench

Host-side UART initiator for the PUF challenge/response link. It serialises a 16-bit challenge as two 8N1 UART frames on `tx`. It then listens on `rx` for the device's two-frame 16-bit response and presents the assembled word with a one-cycle valid strobe. Timeout and frame-error reporting let the host retry. It sits in the host/tester FPGA, wired directly to the device board's UART pins.

---
 rtl/puf_host_link.sv | 174 +++++++++++++++++
 tb/tb_puf_host_link.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/puf_host_link.sv
// puf_host_link: host-side UART initiator for the PUF challenge/response link.
// Sends a 16-bit challenge as two 8N1 frames (low byte first), then receives
// a two-frame 16-bit response, with timeout and stop-bit error reporting.
// Optional build macro PUF_HOST_GRAY_EN: transmit the challenge as Gray code.
module puf_host_link #(
    parameter int CLKS_PER_BIT   = 868,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] challenge,
    output logic        busy,
    output logic        tx,
    input  logic        rx,
    output logic [15:0] response,
    output logic        resp_valid,
    output logic        timeout,
    output logic        frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, TX_LO, TX_HI, RX_LO, RX_HI, DONE} state_t;

    state_t        state_q;
    logic          tx_q, busy_q, resp_valid_q, timeout_q, frame_err_q;
    logic [15:0]   resp_q;
    logic [18:0]   tx_sh_q;     // bits still to send after the current one
    logic [CW-1:0] tx_cnt_q;
    logic [4:0]    tx_bit_q;    // 0..19 across both frames
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic          rx_act_q;    // a frame is being received
    logic [CW-1:0] rx_cnt_q;
    logic [3:0]    rx_bit_q;    // 0 start, 1..8 data, 9 stop
    logic [7:0]    rx_sh_q, rx_lo_q;
    logic [TW-1:0] to_cnt_q;

    logic [15:0]   chal_d;
    logic          stop_smp_d, rx_fall_d, rx_smp_d;

    // Word actually placed on the wire
`ifdef PUF_HOST_GRAY_EN
    assign chal_d = challenge ^ (challenge >> 1);
`else
    assign chal_d = challenge;
`endif

    assign rx_fall_d  = rx_prev_q & ~rx_s2_q;
    assign rx_smp_d   = rx_act_q &&
                        (rx_cnt_q == ((rx_bit_q == 4'd0) ? HALF_LAST : BIT_LAST));
    assign stop_smp_d = rx_smp_d && (rx_bit_q == 4'd9);

    // Main controller: TX serialiser, RX deserialiser, timeout and strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            tx_sh_q      <= '0;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_act_q     <= 1'b0;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_sh_q      <= '0;
            rx_lo_q      <= '0;
            to_cnt_q     <= '0;
        end else begin
            rx_s1_q      <= rx;
            rx_s2_q      <= rx_s1_q;
            rx_prev_q    <= rx_s2_q;
            resp_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= TX_LO;
                        busy_q   <= 1'b1;
                        tx_q     <= 1'b0;  // low-byte start bit
                        tx_sh_q  <= {1'b1, chal_d[15:8], 1'b0, 1'b1, chal_d[7:0]};
                        tx_cnt_q <= '0;
                        tx_bit_q <= '0;
                    end
                end
                TX_LO, TX_HI: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 5'd19) begin
                            // high-byte stop bit done: arm the receiver
                            state_q  <= RX_LO;
                            tx_q     <= 1'b1;
                            to_cnt_q <= '0;
                            rx_act_q <= 1'b0;
                        end else begin
                            tx_bit_q <= tx_bit_q + 5'd1;
                            tx_q     <= tx_sh_q[0];
                            tx_sh_q  <= {1'b1, tx_sh_q[18:1]};
                            if (tx_bit_q == 5'd9) state_q <= TX_HI;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                RX_LO, RX_HI: begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                    if (stop_smp_d) begin
                        // stop-bit result takes priority over a coincident timeout
                        rx_act_q <= 1'b0;
                        if (!rx_s2_q) begin
                            frame_err_q <= 1'b1;
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                        end else if (state_q == RX_LO) begin
                            rx_lo_q <= rx_sh_q;
                            state_q <= RX_HI;
                        end else begin
                            resp_q       <= {rx_sh_q, rx_lo_q};
                            resp_valid_q <= 1'b1;
                            state_q      <= DONE;
                        end
                    end else if (to_cnt_q >= TO_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        rx_act_q  <= 1'b0;
                    end else if (!rx_act_q) begin
                        if (rx_fall_d) begin
                            rx_act_q <= 1'b1;
                            rx_cnt_q <= '0;
                            rx_bit_q <= '0;
                        end
                    end else if (rx_smp_d) begin
                        rx_cnt_q <= '0;
                        if (rx_bit_q == 4'd0 && rx_s2_q) begin
                            rx_act_q <= 1'b0;  // start bit did not hold: glitch
                        end else begin
                            rx_bit_q <= rx_bit_q + 4'd1;
                            if (rx_bit_q != 4'd0) rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign response   = resp_q;
    assign resp_valid = resp_valid_q;
    assign timeout    = timeout_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_puf_host_link.sv
// Bench for puf_host_link: directed and randomized transactions checked
// against a line-level model of the UART frames and the transaction rules.
module tb_puf_host_link;
    localparam int CPB = 4;
    localparam int TO  = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] challenge = '0;
    logic        busy, tx, resp_valid, timeout, frame_err;
    logic        rx = 1'b1;
    logic [15:0] response;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Strobe monitor state
    int rv_n = 0, to_n = 0, fe_n = 0, multi = 0;
    int rv_cyc = -1, to_cyc = -1, bfall_cyc = -1;
    logic [15:0] rv_val = '0;
    logic busy_prev = 1'b0;
    int mon_s;

    logic [15:0] model_resp = '0;

    puf_host_link #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge),
        .busy(busy), .tx(tx), .rx(rx), .response(response),
        .resp_valid(resp_valid), .timeout(timeout), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        mon_s = int'(resp_valid === 1'b1) + int'(timeout === 1'b1) + int'(frame_err === 1'b1);
        if (mon_s > 1) multi++;
        if (resp_valid === 1'b1) begin rv_n++; rv_cyc = cyc; rv_val = response; end
        if (timeout === 1'b1) begin to_n++; to_cyc = cyc; end
        if (frame_err === 1'b1) fe_n++;
        if (busy_prev === 1'b1 && busy === 1'b0) bfall_cyc = cyc;
        busy_prev = busy;
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_word(input logic [15:0] c);
`ifdef PUF_HOST_GRAY_EN
        return c ^ (c >> 1);
`else
        return c;
`endif
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stopb, output int stop_cyc);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        stop_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            if (i == 9) stop_cyc = cyc;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    // mode 0: good reply, 1: high-byte stop bit 0, 2: no reply
    task automatic do_txn(input logic [15:0] ch, input logic [15:0] rep, input int mode,
                          input bit noisy, input bit glitch);
        logic [15:0] w, prev;
        logic [19:0] bits;
        logic [79:0] wave, exp_wave;
        logic [7:0]  lo_b, hi_b;
        int n, rv0, to0, fe0, sc, dly;
        w    = model_word(ch);
        // line order: start, lo LSB first, stop, start, hi LSB first, stop
        bits = {1'b1, w[15:8], 1'b0, 1'b1, w[7:0], 1'b0};
        for (int i = 0; i < 80; i++) exp_wave[i] = bits[i / CPB];
        prev = model_resp;
        rv0 = rv_n; to0 = to_n; fe0 = fe_n;
        repeat (3) @(negedge clk);
        challenge = ch;
        start = 1'b1;
        n = cyc;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0;
                chk("busy_after_start", busy, 1'b1);
            end
            wave[i] = tx;
            if (noisy) begin
                rx = (i < 60) ? 1'($urandom) : 1'b1;
                if (i == 20) begin start = 1'b1; challenge = 16'($urandom); end
                if (i == 21) start = 1'b0;
            end
        end
        chk("tx_wave", wave, exp_wave);
        for (int k = 0; k < 8; k++) begin
            lo_b[k] = wave[CPB * (1 + k) + 2];
            hi_b[k] = wave[CPB * (11 + k) + 2];
        end
        chk("tx_lo_byte", lo_b, w[7:0]);
        chk("tx_hi_byte", hi_b, w[15:8]);
        @(negedge clk);  // RX arm cycle N+1+20*CPB
        chk("arm_tx_idle", tx, 1'b1);
        chk("arm_busy", busy, 1'b1);
        if (mode == 2) begin
            repeat (TO + 5) @(negedge clk);
            chk("to_count", to_n, to0 + 1);
            chk("to_cycle", to_cyc, n + 1 + 20 * CPB + TO);
            chk("to_no_valid", rv_n, rv0);
            chk("to_resp_kept", response, prev);
            chk("to_busy_low", busy, 1'b0);
        end else begin
            dly = $urandom_range(15, 1);
            repeat (dly) @(negedge clk);
            if (glitch) begin
                rx = 1'b0;
                @(negedge clk);
                rx = 1'b1;
                repeat (6) @(negedge clk);
            end
            send_frame(rep[7:0], 1'b1, sc);
            repeat ($urandom_range(3, 0)) @(negedge clk);
            send_frame(rep[15:8], (mode == 0), sc);
            repeat (10) @(negedge clk);
            chk("no_timeout", to_n, to0);
            if (mode == 0) begin
                chk("rv_count", rv_n, rv0 + 1);
                chk("no_frame_err", fe_n, fe0);
                chk("resp_at_valid", rv_val, rep);
                chk("resp_held", response, rep);
                chk("rv_latency", (rv_cyc >= sc + 3) && (rv_cyc <= sc + 6), 1'b1);
                chk("busy_fall", bfall_cyc, rv_cyc + 1);
                model_resp = rep;
            end else begin
                chk("fe_count", fe_n, fe0 + 1);
                chk("fe_no_valid", rv_n, rv0);
                chk("fe_resp_kept", response, prev);
                chk("fe_busy_low", busy, 1'b0);
            end
        end
    endtask

    initial begin
        int n, rv0, to0, fe0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_response", response, 16'h0000);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);

        do_txn(16'h1234, 16'hABCD, 0, 1'b0, 1'b0);
        do_txn(16'h0003, 16'h5A5A, 0, 1'b0, 1'b0);
        do_txn(16'($urandom), 16'h0, 2, 1'b0, 1'b0);
        do_txn(16'($urandom), 16'($urandom), 1, 1'b0, 1'b0);
        do_txn(16'($urandom), 16'($urandom), 0, 1'b0, 1'b1);
        for (int t = 0; t < 6; t++)
            do_txn(16'($urandom), 16'($urandom), 0, 1'b1, 1'($urandom));

        // reset in the middle of the high-byte frame
        repeat (3) @(negedge clk);
        rv0 = rv_n; to0 = to_n; fe0 = fe_n;
        challenge = 16'($urandom);
        start = 1'b1;
        n = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (14 * CPB) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_response", response, 16'h0000);
        rst = 1'b0;
        model_resp = 16'h0000;
        repeat (TO + 30 * CPB) @(negedge clk);
        chk("midrst_no_strobes", {rv_n, to_n, fe_n}, {rv0, to0, fe0});

        do_txn(16'($urandom), 16'($urandom), 0, 1'b0, 1'b0);
        chk("strobes_exclusive", multi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
